// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver, LSB first, single sample per bit.
// Ports: clk, rst_n (async low), rxd (serial in, idle high),
//   rx_data (last good byte, held), rx_done (1-cycle strobe with
//   rx_data update), frame_err (1-cycle strobe on low stop bit),
//   busy (FSM not idle).
`timescale 1ns/1ps
module uart_rx_byte #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       busy
);

  localparam int BAUD_CNT = CLK_FREQ / BAUD;
  localparam int HALF_CNT = BAUD_CNT / 2;
  localparam int CW = $clog2(BAUD_CNT + 1);

  localparam logic [CW-1:0] C_LAST = CW'(BAUD_CNT - 1);
  localparam logic [CW-1:0] C_HALF = CW'(HALF_CNT - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_done;
  logic          r_ferr;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_prev;

  logic w_fall;
  logic w_tick;

  // Edge registers reset to 0, so a line low through reset
  // never looks like a start edge.
  assign w_fall = r_prev & ~r_sync2;
  assign w_tick = (r_cnt == C_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_ferr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_bit <= '0;
          if (w_fall) begin
            r_state <= S_START;
            r_cnt   <= '0;
          end
        end
        // Counter restarts at mid start bit so later
        // samples fall on full-bit wraps.
        S_START: begin
          if (r_cnt == C_HALF) begin
            r_cnt <= '0;
            if (r_sync2) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_DATA;
              r_bit   <= '0;
            end
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        S_DATA: begin
          r_cnt <= w_tick ? '0 : r_cnt + C_ONE;
          if (w_tick) begin
            r_shift <= {r_sync2, r_shift[7:1]};
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bit <= r_bit + 3'd1;
            end
          end
        end
        S_STOP: begin
          r_cnt <= w_tick ? '0 : r_cnt + C_ONE;
          if (w_tick) begin
            if (r_sync2) begin
              r_data  <= r_shift;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= S_WAIT;
            end
          end
        end
        // Hold off until the line recovers so a break
        // cannot start a new frame.
        S_WAIT: begin
          if (r_sync2) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rx_data   = r_data;
  assign rx_done   = r_done;
  assign frame_err = r_ferr;
  assign busy      = (r_state != S_IDLE);

endmodule
